vec_pipe_ctrl: RTL and testbench
================================

Name: vec_pipe_ctrl

Overview:
- Registered, parametrised successor to the combinational decode/control unit of the vector alpha-compositing ASIP.
- Decodes {op,inst} and launches a registered control word into the EX stage.
- Adds three behaviours:
  - load-use hazard stall;
  - jump flush;
  - multi-beat sequencing of vector ALU ops when VLEN exceeds the physical lane count.

Parameters:
- VLEN, 16, vector length in elements.
- LANES, 4, elements processed per cycle; VLEN % LANES must be 0. BEATS = VLEN/LANES.
- REG_AW, 4, register address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- instr_valid  in  1  decode stage holds a valid instruction.
- op  in  2  opcode class.
- inst  in  2  sub-op.
- rd, rs1, rs2  in  REG_AW  dest/source register addresses.
- flag_v  in  1  compare flag from EX.
- stall_o  out  1  hold fetch/decode.
- flush_o  out  1  kill the instruction in decode.
- ctrl_valid  out  1  EX control word valid.
- wmem, rmem, wreg, cond_en  out  1  registered control strobes.
- jmp_f  out  2  [0] any jump, [1] jump-if-equal.
- alu_ins  out  3  ALU opcode.
- ext_sel  out  2  extender select.
- rmux_sel  out  2  writeback mux select.
- rd_q  out  REG_AW  registered destination.
- beat_idx  out  $clog2(BEATS) (min 1)  current lane-group index.

Behaviour:
- Decode (package function, combinational, then registered):
  - wmem = op==01 && inst==00.
  - rmem = op==11 && inst==01.
  - wreg = op[1].
  - jmp_f[0] = op==00 && !inst[1]; jmp_f[1] = op==00 && inst==01.
  - cond_en = op==01 && inst!=00.
  - alu_ins: op==10 -> {0,inst}; op==11 && inst==00 -> 100; else 000.
  - ext_sel: op==00 -> 11; op==11 && inst==00 -> 10; rmem or op==01 -> 01; else 00.
  - rmux_sel: rmem -> 01; op==11 && inst==00 -> 10; else 00.
- Reset: all outputs 0, state IDLE, beat_idx 0, stall_o 0, flush_o 0.
- Accept occurs when instr_valid && !stall_o && !flush_o. On accept, the control word appears on outputs the next cycle with ctrl_valid=1 (latency 1).
- Bubble: no accept leaves ctrl_valid=0 and all strobes 0. Other fields hold their previous values (don't-care).
- Load-use hazard:
  - Condition: ctrl_valid && rmem && rd_q!=0 && instr_valid && (rd_q==rs1 || rd_q==rs2).
  - Response: stall_o=1 combinationally for exactly one cycle and insert one bubble.
  - The stalled instruction is accepted the following cycle.
- Jump:
  - Taken = jmp_f[0] && (!jmp_f[1] || flag_v), evaluated while the jump sits in EX (ctrl_valid=1).
  - flush_o=1 combinationally that cycle. The decode instruction is not accepted; a bubble follows.
  - JEQ with flag_v=0 does not flush.
- Multi-beat vector op:
  - Applies to op==10 when BEATS>1.
  - FSM: IDLE -> BEAT on accept. In BEAT, stall_o=1, ctrl_valid=1 and the control word is held.
  - beat_idx increments 0..BEATS-1 with wreg each beat. On beat_idx==BEATS-1, stall_o drops and the FSM returns to IDLE; an accept on that cycle is allowed.
  - BEATS==1: no BEAT state and beat_idx stays 0.
- Priority: reset > flush > multi-beat stall > hazard stall > accept.
  - Flush during BEAT cannot occur: op==10 is never a jump.
  - Hazard with a multi-beat op in EX is not possible (no load in EX); the FSM is checked first regardless.
- Reset mid-BEAT: immediate return to IDLE, beat_idx 0, outputs cleared.

Decomposition:
- Package vec_ctrl_pkg holds:
  - op class localparams (OP_JMP=00, OP_MEM=01, OP_ALU=10, OP_LD=11);
  - ctrl_word_t packed struct (wmem, rmem, wreg, cond_en, jmp_f, alu_ins, ext_sel, rmux_sel);
  - function decode_ctrl(op,inst) returning ctrl_word_t.
- One sub-module, vec_beat_seq: the IDLE/BEAT FSM plus beat counter, parametrised by BEATS, exposing busy and last_beat.

Test Plan:
- Reset mid-BEAT: release after reset -> all outputs 0. Assert rst_n low during beat 2 of a vector op -> next edge beat_idx=0, ctrl_valid=0, stall_o=0.
- Store op=01 inst=00 accepted -> next cycle ctrl_valid=1, wmem=1, ext_sel=01, wreg=0, stall_o stays 0.
- Load op=11 inst=01 rd=3, then add op=10 rs1=3 -> one cycle stall_o=1, one bubble (ctrl_valid=0), then the add is issued with alu_ins=000.
- JEQ op=00 inst=01 with flag_v=1 -> flush_o=1 for one cycle, the following instruction is dropped, ctrl_valid=0 next cycle. Repeat with flag_v=0 -> no flush.
- VLEN=16, LANES=4, vector op op=10 inst=11 -> 4 cycles ctrl_valid=1, alu_ins=011, beat_idx 0,1,2,3. stall_o is high during beats 0-2 and low on beat 3; the next instruction is accepted on beat 3.
- Load rd=0 followed by a consumer of r0 -> no stall.

Source files
------------

// File: rtl/vec_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vec_ctrl_pkg
// Description : Opcode classes, EX control word and decode function for the
//               vector alpha-compositing ASIP pipeline controller.
// Revision    : 1.0
// ============================================================================
package vec_ctrl_pkg;

   localparam logic [1:0] OP_JMP = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_ALU = 2'b10;
   localparam logic [1:0] OP_LD  = 2'b11;

   typedef struct packed {
      logic       wmem;
      logic       rmem;
      logic       wreg;
      logic       cond_en;
      logic [1:0] jmp_f;
      logic [2:0] alu_ins;
      logic [1:0] ext_sel;
      logic [1:0] rmux_sel;
   } ctrl_word_t;

   localparam ctrl_word_t CTRL_NOP = '0;

   function automatic ctrl_word_t decode_ctrl(input logic [1:0] op, input logic [1:0] inst);
      ctrl_word_t w;
      logic       is_ldi;
      w      = CTRL_NOP;
      // op==11/inst==00 loads an immediate through the ALU path
      is_ldi = (op == OP_LD) && (inst == 2'b00);

      w.wmem     = (op == OP_MEM) && (inst == 2'b00);
      w.rmem     = (op == OP_LD) && (inst == 2'b01);
      w.wreg     = op[1];
      w.jmp_f[0] = (op == OP_JMP) && !inst[1];
      w.jmp_f[1] = (op == OP_JMP) && (inst == 2'b01);
      w.cond_en  = (op == OP_MEM) && (inst != 2'b00);

      if (op == OP_ALU) begin
         w.alu_ins = {1'b0, inst};
      end else if (is_ldi) begin
         w.alu_ins = 3'b100;
      end

      if (op == OP_JMP) begin
         w.ext_sel = 2'b11;
      end else if (is_ldi) begin
         w.ext_sel = 2'b10;
      end else if (w.rmem || (op == OP_MEM)) begin
         w.ext_sel = 2'b01;
      end

      if (w.rmem) begin
         w.rmux_sel = 2'b01;
      end else if (is_ldi) begin
         w.rmux_sel = 2'b10;
      end

      return w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vec_beat_seq.sv
`default_nettype none
// ============================================================================
// Module      : vec_beat_seq
// Description : IDLE/BEAT sequencer stepping a vector op across BEATS lane
//               groups; flags busy and the final beat.
// Revision    : 1.0
// ============================================================================
module vec_beat_seq #(
   parameter  int BEATS = 4,
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   output logic          busy,
   output logic          last_beat,
   output logic [BW-1:0] beat_idx
);

   generate
      if (BEATS > 1) begin : g_multi
         localparam logic [0:0]    S_IDLE = 1'b0;
         localparam logic [0:0]    S_BEAT = 1'b1;
         localparam logic [BW-1:0] C_LAST = BW'(BEATS - 1);

         logic [0:0]    r_state;
         logic [0:0]    w_next;
         logic [BW-1:0] r_cnt;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_state <= S_IDLE;
            end else begin
               r_state <= w_next;
            end
         end

         // A fresh vector op accepted on the last beat restarts the sequence
         always_comb begin
            w_next = r_state;
            case (r_state)
               S_IDLE:  if (start) w_next = S_BEAT;
               S_BEAT:  if ((r_cnt == C_LAST) && !start) w_next = S_IDLE;
               default: w_next = S_IDLE;
            endcase
         end

         always_comb begin
            busy      = 1'b0;
            last_beat = 1'b0;
            case (r_state)
               S_BEAT: begin
                  busy      = 1'b1;
                  last_beat = (r_cnt == C_LAST);
               end
               default: begin
                  busy      = 1'b0;
                  last_beat = 1'b0;
               end
            endcase
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_cnt <= '0;
            end else if (busy && !last_beat) begin
               r_cnt <= r_cnt + 1'b1;
            end else begin
               r_cnt <= '0;
            end
         end

         assign beat_idx = r_cnt;
      end else begin : g_single
         logic w_unused_single;
         assign w_unused_single = &{1'b0, clk, rst_n, start};
         assign busy            = 1'b0;
         assign last_beat       = 1'b0;
         assign beat_idx        = '0;
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/vec_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vec_pipe_ctrl
// Description : Registered decode/control for the vector ASIP with load-use
//               stall, jump flush and multi-beat vector ALU sequencing.
// Revision    : 1.0
// ============================================================================
module vec_pipe_ctrl
   import vec_ctrl_pkg::*;
#(
   parameter  int VLEN   = 16,
   parameter  int LANES  = 4,
   parameter  int REG_AW = 4,
   localparam int BEATS  = VLEN / LANES,
   localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              instr_valid,
   input  logic [1:0]        op,
   input  logic [1:0]        inst,
   input  logic [REG_AW-1:0] rd,
   input  logic [REG_AW-1:0] rs1,
   input  logic [REG_AW-1:0] rs2,
   input  logic              flag_v,
   output logic              stall_o,
   output logic              flush_o,
   output logic              ctrl_valid,
   output logic              wmem,
   output logic              rmem,
   output logic              wreg,
   output logic              cond_en,
   output logic [1:0]        jmp_f,
   output logic [2:0]        alu_ins,
   output logic [1:0]        ext_sel,
   output logic [1:0]        rmux_sel,
   output logic [REG_AW-1:0] rd_q,
   output logic [BW-1:0]     beat_idx
);

   ctrl_word_t        r_ctrl;
   ctrl_word_t        w_dec;
   logic              r_valid;
   logic [REG_AW-1:0] r_rd;

   logic w_taken;
   logic w_hazard;
   logic w_beat_stall;
   logic w_accept;
   logic w_start;
   logic w_busy;
   logic w_last;

   assign w_dec = decode_ctrl(op, inst);

   assign w_taken = r_valid && r_ctrl.jmp_f[0] && (!r_ctrl.jmp_f[1] || flag_v);

   assign w_hazard = r_valid && r_ctrl.rmem && (r_rd != '0) && instr_valid
                     && ((r_rd == rs1) || (r_rd == rs2));

   assign w_beat_stall = w_busy && !w_last;

   // Flush wins over any stall; beat sequencing outranks the load-use hazard
   assign flush_o  = w_taken;
   assign stall_o  = !w_taken && (w_beat_stall || w_hazard);
   assign w_accept = instr_valid && !stall_o && !flush_o;
   assign w_start  = w_accept && (op == OP_ALU);

   vec_beat_seq #(
      .BEATS (BEATS)
   ) u_beat_seq (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (w_start),
      .busy      (w_busy),
      .last_beat (w_last),
      .beat_idx  (beat_idx)
   );

   // Non-strobe fields keep their last value through bubbles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ctrl  <= CTRL_NOP;
         r_valid <= 1'b0;
         r_rd    <= '0;
      end else if (w_accept) begin
         r_ctrl  <= w_dec;
         r_valid <= 1'b1;
         r_rd    <= rd;
      end else if (w_beat_stall) begin
         r_valid <= 1'b1;
      end else begin
         r_valid         <= 1'b0;
         r_ctrl.wmem     <= 1'b0;
         r_ctrl.rmem     <= 1'b0;
         r_ctrl.wreg     <= 1'b0;
         r_ctrl.cond_en  <= 1'b0;
         r_ctrl.jmp_f    <= 2'b00;
      end
   end

   assign ctrl_valid = r_valid;
   assign wmem       = r_ctrl.wmem;
   assign rmem       = r_ctrl.rmem;
   assign wreg       = r_ctrl.wreg;
   assign cond_en    = r_ctrl.cond_en;
   assign jmp_f      = r_ctrl.jmp_f;
   assign alu_ins    = r_ctrl.alu_ins;
   assign ext_sel    = r_ctrl.ext_sel;
   assign rmux_sel   = r_ctrl.rmux_sel;
   assign rd_q       = r_rd;

endmodule
`default_nettype wire

// File: tb/tb_vec_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vec_pipe_ctrl
// Description : Self-checking bench for vec_pipe_ctrl with a cycle model.
// Revision    : 1.0
// ============================================================================
module tb_vec_pipe_ctrl;

   localparam int VLEN  = 16;
   localparam int LANES = 4;
   localparam int BEATS = VLEN / LANES;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       instr_valid;
   logic [1:0] op, inst;
   logic [3:0] rd, rs1, rs2;
   logic       flag_v;
   logic       stall_o, flush_o, ctrl_valid, wmem, rmem, wreg, cond_en;
   logic [1:0] jmp_f, ext_sel, rmux_sel, beat_idx;
   logic [2:0] alu_ins;
   logic [3:0] rd_q;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic       wmem, rmem, wreg, cond;
      logic [1:0] jmp;
      logic [2:0] alu;
      logic [1:0] ext, rmux;
   } mw_t;

   mw_t        m_w;
   logic       m_valid;
   logic [3:0] m_rd;
   int         m_left;
   logic       m_vec;
   logic       m_acc = 1'b0;
   logic       e_flush, e_stall, e_hazard;
   int         e_beat;

   vec_pipe_ctrl #(.VLEN(VLEN), .LANES(LANES), .REG_AW(4)) dut (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .op(op), .inst(inst),
      .rd(rd), .rs1(rs1), .rs2(rs2), .flag_v(flag_v), .stall_o(stall_o),
      .flush_o(flush_o), .ctrl_valid(ctrl_valid), .wmem(wmem), .rmem(rmem),
      .wreg(wreg), .cond_en(cond_en), .jmp_f(jmp_f), .alu_ins(alu_ins),
      .ext_sel(ext_sel), .rmux_sel(rmux_sel), .rd_q(rd_q), .beat_idx(beat_idx)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Instruction table written per opcode class
   function automatic mw_t exp_word(input logic [1:0] o, input logic [1:0] i);
      mw_t w;
      w = '0;
      case (o)
         2'b00: begin
            w.ext = 2'b11;
            if (i == 2'b00) w.jmp = 2'b01;
            if (i == 2'b01) w.jmp = 2'b11;
         end
         2'b01: begin
            w.ext = 2'b01;
            if (i == 2'b00) w.wmem = 1'b1;
            else            w.cond = 1'b1;
         end
         2'b10: begin
            w.wreg = 1'b1;
            w.alu  = {1'b0, i};
         end
         default: begin
            w.wreg = 1'b1;
            if (i == 2'b00) begin
               w.alu = 3'b100; w.ext = 2'b10; w.rmux = 2'b10;
            end else if (i == 2'b01) begin
               w.rmem = 1'b1; w.ext = 2'b01; w.rmux = 2'b01;
            end
         end
      endcase
      return w;
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         m_acc = 1'b0;
         chk("rst_outs", {stall_o, flush_o, ctrl_valid, wmem, rmem, wreg, cond_en, jmp_f, beat_idx}, 32'd0);
      end else begin
         e_flush  = m_valid && m_w.jmp[0] && (!m_w.jmp[1] || flag_v);
         e_hazard = m_valid && m_w.rmem && (m_rd != 4'd0) && instr_valid
                    && ((m_rd == rs1) || (m_rd == rs2));
         e_stall  = !e_flush && ((m_left > 0) || e_hazard);
         m_acc    = instr_valid && !e_stall && !e_flush;
         e_beat   = (m_valid && m_vec) ? (BEATS - 1 - m_left) : 0;
         chk("cyc_ctl", {stall_o, flush_o, ctrl_valid, wmem, rmem, wreg, cond_en, jmp_f},
             {e_stall, e_flush, m_valid, m_w.wmem, m_w.rmem, m_w.wreg, m_w.cond, m_w.jmp});
         chk("cyc_beat", {30'd0, beat_idx}, e_beat);
         if (m_valid)
            chk("cyc_fld", {alu_ins, ext_sel, rmux_sel, rd_q}, {m_w.alu, m_w.ext, m_w.rmux, m_rd});
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_w <= '0; m_valid <= 1'b0; m_rd <= 4'd0; m_left <= 0; m_vec <= 1'b0;
      end else if (m_acc) begin
         m_w     <= exp_word(op, inst);
         m_valid <= 1'b1;
         m_rd    <= rd;
         m_vec   <= (op == 2'b10) && (BEATS > 1);
         m_left  <= ((op == 2'b10) && (BEATS > 1)) ? BEATS - 1 : 0;
      end else if (m_left > 0) begin
         m_left <= m_left - 1;
      end else begin
         m_valid <= 1'b0; m_vec <= 1'b0;
         m_w.wmem <= 1'b0; m_w.rmem <= 1'b0; m_w.wreg <= 1'b0; m_w.cond <= 1'b0; m_w.jmp <= 2'b00;
      end
   end

   task automatic put(input logic [1:0] o, input logic [1:0] i, input logic [3:0] d,
                      input logic [3:0] a, input logic [3:0] b, input logic f);
      op = o; inst = i; rd = d; rs1 = a; rs2 = b; flag_v = f; instr_valid = 1'b1;
   endtask

   task automatic wait_acc(input bit once, output int n);
      n = 0;
      do begin
         @(posedge clk);
         n++;
      end while (!m_acc && !once && n < 40);
      if (!once && !m_acc) begin
         total++; bad++;
         $display("FAIL acc_timeout: got no accept want accept within %0d cycles", n);
      end
      #1;
      instr_valid = 1'b0;
   endtask

   task automatic issue(input logic [1:0] o, input logic [1:0] i, input logic [3:0] d,
                        input logic [3:0] a, input logic [3:0] b, input logic f);
      int n;
      put(o, i, d, a, b, f);
      wait_acc(1'b0, n);
   endtask

   task automatic idle(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_n = 1'b0; instr_valid = 1'b0; op = 2'b00; inst = 2'b00;
      rd = 4'd0; rs1 = 4'd0; rs2 = 4'd0; flag_v = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1 chk("reset_state", {ctrl_valid, stall_o, flush_o, wmem, rmem, wreg, cond_en, jmp_f,
                             alu_ins, ext_sel, rmux_sel, rd_q, beat_idx}, 32'd0);
      idle(1);

      // store
      issue(2'b01, 2'b00, 4'd5, 4'd1, 4'd2, 1'b0);
      chk("store_word", {ctrl_valid, wmem, ext_sel, wreg, stall_o}, 6'b110100);

      // load r3 then add using r3
      issue(2'b11, 2'b01, 4'd3, 4'd0, 4'd0, 1'b0);
      chk("load_word", {rmem, wreg, ext_sel, rmux_sel}, 6'b110101);
      put(2'b10, 2'b00, 4'd7, 4'd3, 4'd4, 1'b0);
      #1 chk("hazard_stall", {31'd0, stall_o}, 32'd1);
      @(posedge clk);
      #1 chk("hazard_bubble", {ctrl_valid, stall_o}, 2'b00);
      wait_acc(1'b0, n);
      chk("hazard_release", n, 32'd1);
      chk("add_word", {ctrl_valid, alu_ins, wreg, rd_q}, {1'b1, 3'b000, 1'b1, 4'd7});
      idle(4);

      // taken JEQ drops the next instruction
      issue(2'b00, 2'b01, 4'd0, 4'd0, 4'd0, 1'b1);
      put(2'b01, 2'b00, 4'd1, 4'd0, 4'd0, 1'b1);
      #1 chk("jeq_flush", {31'd0, flush_o}, 32'd1);
      wait_acc(1'b1, n);
      chk("jeq_drop", {ctrl_valid, flush_o, wmem}, 3'b000);

      // not-taken JEQ
      issue(2'b00, 2'b01, 4'd0, 4'd0, 4'd0, 1'b0);
      put(2'b01, 2'b00, 4'd1, 4'd0, 4'd0, 1'b0);
      #1 chk("jne_noflush", {31'd0, flush_o}, 32'd0);
      wait_acc(1'b0, n);
      chk("jne_cycles", n, 32'd1);
      chk("jne_store", {ctrl_valid, wmem}, 2'b11);

      // four-beat vector op, next instruction accepted on the last beat
      issue(2'b10, 2'b11, 4'd9, 4'd1, 4'd2, 1'b0);
      chk("vec_b0", {ctrl_valid, alu_ins, beat_idx, stall_o}, {1'b1, 3'b011, 2'd0, 1'b1});
      put(2'b01, 2'b00, 4'd2, 4'd0, 4'd0, 1'b0);
      for (int b = 1; b < 4; b++) begin
         @(posedge clk);
         #1 chk("vec_beat", {ctrl_valid, wreg, beat_idx, stall_o}, {1'b1, 1'b1, 2'(b), (b != 3)});
      end
      @(posedge clk);
      #1 instr_valid = 1'b0;
      chk("after_vec", {ctrl_valid, wmem, beat_idx}, 4'b1100);

      // load to r0 never stalls
      issue(2'b11, 2'b01, 4'd0, 4'd0, 4'd0, 1'b0);
      put(2'b10, 2'b00, 4'd4, 4'd0, 4'd0, 1'b0);
      #1 chk("r0_nostall", {31'd0, stall_o}, 32'd0);
      wait_acc(1'b0, n);
      chk("r0_cycles", n, 32'd1);
      idle(5);

      // reset during beat 2
      issue(2'b10, 2'b01, 4'd6, 4'd0, 4'd0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1 chk("mid_b2", {30'd0, beat_idx}, 32'd2);
      rst_n = 1'b0;
      #1 chk("mid_rst", {beat_idx, ctrl_valid, stall_o, wreg}, 5'b00000);
      @(posedge clk);
      #1 rst_n = 1'b1;
      idle(2);
      chk("post_rst", {ctrl_valid, beat_idx, stall_o}, 4'b0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
